// File: rtl/isqrt_pkg.sv
// Shared widths and state encoding for the iterative integer square root engine.
package isqrt_pkg;

  localparam int ISQRT_X_W   = 32;
  localparam int ISQRT_Y_W   = 16;
  localparam int ISQRT_REM_W = 18;

  typedef enum logic {
    st_idle = 1'b0,
    st_calc = 1'b1
  } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One radix-2 restoring square-root digit: brings in two radicand bits,
// trial-subtracts (root<<2)|1 and appends the resulting root bit.
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [ISQRT_REM_W-1:0] rem_i,
  input  logic [ISQRT_Y_W-1:0]   root_i,
  input  logic [1:0]             bits_i,
  output logic [ISQRT_REM_W-1:0] rem_o,
  output logic [ISQRT_Y_W-1:0]   root_o
);

  logic [ISQRT_REM_W+1:0] rem_sh;
  logic [ISQRT_REM_W+1:0] trial;
  logic [ISQRT_REM_W-1:0] diff;
  logic                   ge;

  // Compare at full width; the difference only needs the low bits because
  // the remainder never exceeds 2*root.
  always_comb begin
    rem_sh = {rem_i, bits_i};
    trial  = {2'b00, root_i, 2'b01};
    ge     = (rem_sh >= trial);
    diff   = rem_sh[ISQRT_REM_W-1:0] - trial[ISQRT_REM_W-1:0];
    rem_o  = ge ? diff : rem_sh[ISQRT_REM_W-1:0];
    root_o = {root_i[ISQRT_Y_W-2:0], ge};
  end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Iterative 32-bit unsigned integer square root, y = floor(sqrt(x)).
// STEPS_PER_CYCLE result bits per clock (1, 2 or 4); latency 16/STEPS_PER_CYCLE.
// One-entry pending slot catches a request arriving while busy; a further
// request while the slot is full is dropped and drop_err latches.
// Optional macro ISQRT_REM_OUT_EN adds the y_rem output (x - y*y).
//
// Handshake: x_vld is a one-cycle strobe with no ready; y_vld is a one-cycle
// pulse per accepted request and y is meaningful only while y_vld=1.
module isqrt_iter_fsm
  import isqrt_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y,
  output logic                 busy,
  output logic                 drop_err,
`ifdef ISQRT_REM_OUT_EN
  output logic [16:0]          y_rem,
`endif
  output state_t               dbg_state
);

  localparam int LAT   = ISQRT_Y_W / STEPS_PER_CYCLE;
  localparam int CNT_W = 4;

  state_t                 state_q, state_d;
  logic                   start, last;
  logic [ISQRT_X_W-1:0]   start_x;

  logic                   pend_vld_q, pend_vld_d;
  logic [ISQRT_X_W-1:0]   pend_x_q, pend_x_d;
  logic                   drop_d;

  logic [ISQRT_X_W-1:0]   rad_q, rad_in, rad_next;
  logic [ISQRT_REM_W-1:0] rem_q;
  logic [ISQRT_Y_W-1:0]   root_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [ISQRT_REM_W-1:0] rem_c  [STEPS_PER_CYCLE+1];
  logic [ISQRT_Y_W-1:0]   root_c [STEPS_PER_CYCLE+1];

  // Next-state: a start consumes the pending slot first, else x_vld; the
  // last step group returns to idle so that cycle can accept a new request.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last    = 1'b0;
    case (state_q)
      st_idle: begin
        if (pend_vld_q || x_vld) begin
          start   = 1'b1;
          state_d = st_calc;
        end
      end
      st_calc: begin
        if (cnt_q == CNT_W'(LAT - 1)) begin
          last    = 1'b1;
          state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  assign start_x = pend_vld_q ? pend_x_q : x;

  // Pending slot: refilled in the same edge it drains; overflow only in calc.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_x_d   = pend_x_q;
    drop_d     = drop_err;
    if (state_q == st_idle) begin
      if (pend_vld_q) begin
        pend_vld_d = x_vld;
        if (x_vld) pend_x_d = x;
      end
    end else if (x_vld) begin
      if (!pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_x_d   = x;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Step chain input: the starting edge already resolves the first group,
  // which is what makes the result land exactly LAT cycles after the request.
  always_comb begin
    rem_c[0]  = (state_q == st_calc) ? rem_q  : '0;
    root_c[0] = (state_q == st_calc) ? root_q : '0;
    rad_in    = (state_q == st_calc) ? rad_q  : start_x;
    rad_next  = rad_in << (2 * STEPS_PER_CYCLE);
  end

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    isqrt_step u_step (
      .rem_i  (rem_c[g]),
      .root_i (root_c[g]),
      .bits_i (rad_in[ISQRT_X_W-1-2*g -: 2]),
      .rem_o  (rem_c[g+1]),
      .root_o (root_c[g+1])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= st_idle;
    else      state_q <= state_d;
  end

  // Pending slot and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_x_q   <= '0;
      drop_err   <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_x_q   <= pend_x_d;
      drop_err   <= drop_d;
    end
  end

  // Datapath: advance one step group per cycle while starting or calculating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (start || (state_q == st_calc)) begin
      rad_q  <= rad_next;
      rem_q  <= rem_c[STEPS_PER_CYCLE];
      root_q <= root_c[STEPS_PER_CYCLE];
      cnt_q  <= start ? CNT_W'(1) : cnt_q + 1'b1;
    end
  end

  // Result registers: one-cycle strobe, value held until the next strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_vld <= 1'b0;
      y     <= '0;
`ifdef ISQRT_REM_OUT_EN
      y_rem <= '0;
`endif
    end else begin
      y_vld <= last;
      if (last) begin
        y     <= root_c[STEPS_PER_CYCLE];
`ifdef ISQRT_REM_OUT_EN
        y_rem <= rem_c[STEPS_PER_CYCLE][16:0];
`endif
      end
    end
  end

  assign busy      = (state_q == st_calc);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Bench for isqrt_iter_fsm: directed cases plus random traffic against a
// transaction-level schedule model and a trial-squaring square root.
module tb_isqrt_iter_fsm;
  import isqrt_pkg::*;

  localparam int LAT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic        x_vld, y_vld, busy, drop_err;
  logic [31:0] x;
  logic [15:0] y;
  state_t      dbg_state;
  logic        x4_vld, y4_vld, busy4, drop4;
  logic [31:0] x4;
  logic [15:0] y4;
  state_t      dbg4;
`ifdef ISQRT_REM_OUT_EN
  logic [16:0] y_rem, y4_rem;
`endif

  isqrt_iter_fsm #(.STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(y_vld), .y(y),
    .busy(busy), .drop_err(drop_err),
`ifdef ISQRT_REM_OUT_EN
    .y_rem(y_rem),
`endif
    .dbg_state(dbg_state)
  );

  isqrt_iter_fsm #(.STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .x_vld(x4_vld), .x(x4), .y_vld(y4_vld), .y(y4),
    .busy(busy4), .drop_err(drop4),
`ifdef ISQRT_REM_OUT_EN
    .y_rem(y4_rem),
`endif
    .dbg_state(dbg4)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    longint r = 0;
    for (longint b = 32768; b > 0; b = b >> 1)
      if ((r + b) * (r + b) <= longint'(v)) r = r + b;
    return r[15:0];
  endfunction

  // ---------------- reference schedule model ----------------
  logic [15:0] exp_q[$];
  logic [16:0] exp_rem_q[$];
  int          exp_cyc_q[$];
  int          busy_q[$];
  int          last_start = -1000;
  int          pend_until = -1000;
  int          drop_from  = -1;

  // Engine is occupied for LAT cycles from a start; a single request may
  // wait and starts exactly when the engine frees; anything more is dropped.
  task automatic model_req(input int c, input logic [31:0] v);
    int          s;
    logic [15:0] r;
    if (c >= last_start + LAT) begin
      s = c;
    end else if (c >= pend_until) begin
      s = last_start + LAT;
      pend_until = s;
    end else begin
      if (drop_from < 0) drop_from = c + 1;
      return;
    end
    last_start = s;
    r = ref_isqrt(v);
    exp_q.push_back(r);
    exp_rem_q.push_back(17'(v - 32'(r) * 32'(r)));
    exp_cyc_q.push_back(s + LAT);
    busy_q.push_back(s + 1);
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_rem_q.delete(); exp_cyc_q.delete(); busy_q.delete();
    last_start = -1000;
    pend_until = -1000;
    drop_from  = -1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check("y_vld", y_vld, 1);
        check("y", y, exp_q[0]);
        check("busy_at_done", busy, 0);
`ifdef ISQRT_REM_OUT_EN
        check("y_rem", y_rem, exp_rem_q[0]);
`endif
        void'(exp_q.pop_front());
        void'(exp_rem_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else if (y_vld) begin
        check("y_vld_unexpected", y_vld, 0);
      end
      if (busy_q.size() > 0 && busy_q[0] == cyc) begin
        check("busy", busy, 1);
        void'(busy_q.pop_front());
      end
      check("drop_err", drop_err, (drop_from >= 0 && cyc >= drop_from) ? 1 : 0);
    end
  end

  // ---------------- driver tasks (called negedge-aligned) ----------------
  task automatic issue(input logic [31:0] v);
    x_vld = 1'b1;
    x     = v;
    model_req(cyc, v);
    @(negedge clk);
    x_vld = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic issue4(input logic [31:0] v);
    int n = 1;
    x4_vld = 1'b1;
    x4     = v;
    @(negedge clk);
    x4_vld = 1'b0;
    while (!y4_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lat4", n, 4);
    check("y4", y4, ref_isqrt(v));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    logic [31:0] v;
    rst = 1'b0; x_vld = 1'b0; x = '0; x4_vld = 1'b0; x4 = '0;
    #3;
    check("rst_y_vld", y_vld, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_err, 0);
    check("rst_state", dbg_state, st_idle);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // small values, each issued after the previous result
    issue(0);  drain(40);
    issue(1);  drain(40);
    issue(15); drain(40);

    // extremes
    issue(32'hFFFF_FFFF); drain(40);
    issue(32'hFFFE_0001); drain(40);

    // back-to-back issue in each y_vld cycle
    c0 = cyc;
    issue(16);
    wait_cycle(c0 + LAT);
    issue(25);
    wait_cycle(c0 + 2 * LAT);
    issue(36);
    drain(40);

    // three consecutive requests: third overflows the pending slot
    issue(100); issue(144); issue(169);
    drain(60);
    check("drop_sticky", drop_err, 1);

    // asynchronous reset mid-calculation with the pending slot full
    c0 = cyc;
    issue(100); issue(144);
    wait_cycle(c0 + 8);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_y_vld", y_vld, 0);
    check("arst_y", y, 0);
    check("arst_busy", busy, 0);
    check("arst_drop", drop_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(81); drain(40);

    // four digits per clock
    issue4(1000000);
    issue4(32'hFFFF_FFFF);
    repeat (4) issue4($urandom);

    // random traffic, including overflow of the pending slot
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: v = $urandom;
          1: v = $urandom_range(0, 1000);
          default: begin
            v = $urandom_range(0, 65535);
            v = v * v;
          end
        endcase
        issue(v);
      end else begin
        @(negedge clk);
      end
    end
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isqrt_iter_fsm.md
Name: isqrt_iter_fsm

Overview:
- Iterative 32-bit unsigned integer square root engine; y = floor(sqrt(x)).
- Sits directly downstream of the formula FSMs: consumes their isqrt_x_vld/isqrt_x requests and returns isqrt_y_vld/isqrt_y.
- Digit-by-digit (radix-2 restoring) algorithm, multi-cycle, no backpressure to the requester.
- Has a one-entry pending slot so a request arriving while busy is not lost.

Parameters:
- STEPS_PER_CYCLE, 1, result bits resolved per clock; legal values 1, 2, 4. Latency L = 16 / STEPS_PER_CYCLE.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset: single clock domain; reset is asynchronous and active-low (asserted at 0).
- x_vld  input  1  request strobe, one cycle per request.
- x  input  32  radicand, sampled when x_vld=1.
- y_vld  output  1  result strobe, one-cycle pulse per accepted request.
- y  output  16  floor(sqrt(x)), valid only when y_vld=1.
- busy  output  1  1 while state==st_calc.
- drop_err  output  1  sticky: a request was discarded.

Behaviour:
- Reset (rst=0, async): state=st_idle, y_vld=0, y=0, busy=0, drop_err=0, pending slot empty. Reset mid-calculation aborts silently: no y_vld for the aborted or pending request.
- States: st_idle, st_calc.
- st_idle -> st_calc when a start source exists. Priority: pending slot first, then x_vld.
- st_calc -> st_idle at the edge completing the last step. That same edge registers y_vld=1 and the result into y.
- Latency: request in cycle 0 -> y_vld in cycle L (L=16 for STEPS_PER_CYCLE=1).
- The y_vld cycle is an st_idle cycle, so a request in that cycle is accepted immediately. This is back-to-back issue as the formula FSMs do it: next result L cycles later.
- x_vld in st_calc with pending slot empty: x is stored in the pending slot.
- x_vld in st_idle while the pending slot starts: x goes into the pending slot, which is freed in the same edge.
- x_vld in st_calc with pending slot full: request discarded; drop_err<=1. drop_err clears only on reset.
- Datapath registers:
  - rad: 32b remaining radicand bits, shifted left 2 per step.
  - rem: 18b partial remainder.
  - root: 16b.
  - cnt: step counter.
- Per step:
  - rem' = (rem<<2) | top two bits of rad.
  - trial = (root<<2) | 1.
  - If rem' >= trial: rem = rem' - trial and root = (root<<1) | 1; else rem = rem' and root = root<<1.
- All arithmetic is unsigned, no truncation: the remainder is at most 2*root, so 17 bits suffice (18b register).
- y holds its last value between strobes; y_vld is 0 otherwise.

Optional Feature:
- Macro ISQRT_REM_OUT_EN.
- Defined: adds output y_rem [16:0] = x - y*y, valid with y_vld, reset value 0.
- Undefined: no y_rem port; remainder register is internal only.

Decomposition:
- Package isqrt_pkg:
  - ISQRT_X_W=32, ISQRT_Y_W=16, ISQRT_REM_W=18.
  - state enum typedef (st_idle, st_calc).
- Sub-module isqrt_step: combinational one-digit step (rem, root, 2 radicand bits in -> rem, root out), instantiated STEPS_PER_CYCLE times in a generate chain.

Test Plan:
- x=0, then x=1, then x=15 (issued after each y_vld) -> y=0, 1, 3. With ISQRT_REM_OUT_EN: y_rem=0, 0, 6. Each y_vld exactly 16 cycles after its request.
- x=0xFFFFFFFF -> y=0xFFFF (y_rem=0x1FFFE); x=0xFFFE0001 -> y=0xFFFF (y_rem=0).
- Back-to-back 16, 25, 36: each subsequent request issued in the previous y_vld cycle -> y=4, 5, 6 at cycles 16, 32, 48; drop_err stays 0.
- Requests 100, 144, 169 on three consecutive cycles -> y=10 at cycle 16, y=12 at cycle 32; 169 discarded, drop_err=1 from cycle 3 on.
- rst=0 at cycle 8 of a calc with pending full -> outputs zero immediately (async); no y_vld afterwards. A new x=81 after release -> y=9 sixteen cycles later.
- STEPS_PER_CYCLE=4, x=1000000 -> y=1000, y_vld 4 cycles after request.
